// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port synchronous RAM: write bursts stream straight to the RAM,
// read bursts are pipelined through a 2-entry buffer so the 1-cycle read latency is hidden.
module ram_burst_master #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [AW-1:0]    cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_last,
  output logic             busy,
  output logic             done,
  output logic             ram_we,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // a source keeps valid and its payload stable until that edge.

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q;
  logic [AW-1:0]    remaining_q;
  logic [AW:0]      unissued_q;
  logic [AW-1:0]    last_addr_q;
  logic             inflight_q;
  logic             inflight_last_q;
  logic [WIDTH-1:0] buf_data [2];
  logic             buf_last [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q;
  logic             done_q;

  logic             cmd_hs;
  logic             wr_hs;
  logic             pop;
  logic             push;
  logic             issue;
  logic             final_beat;
  logic [2:0]       occupancy;
  logic [2:0]       capacity;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  assign dbg_state = state_q;
  assign rd_valid  = (count_q != 2'd0);
  assign rd_data   = buf_data[rd_ptr_q];
  assign rd_last   = rd_valid && buf_last[rd_ptr_q];
  assign busy      = (state_q != IDLE) || (count_q != 2'd0);
  assign done      = done_q;

  assign pop    = rd_valid && rd_ready;
  assign push   = inflight_q;
  assign cmd_hs = cmd_valid && cmd_ready;
  assign wr_hs  = (state_q == WRITE) && wr_valid;

  // Credit counts buffered plus in-flight beats; a beat leaving this cycle frees a slot.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
  assign capacity  = 3'd2 + {2'b00, pop};
  assign issue     = (state_q == READ) && (unissued_q != '0) && (occupancy < capacity);

  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    ram_addr   = last_addr_q;
    final_beat = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = cmd_write ? WRITE : READ;
      end
      WRITE: begin
        wr_ready  = 1'b1;
        ram_we    = wr_valid;
        ram_wdata = wr_data;
        ram_addr  = addr_q;
        if (wr_valid && (remaining_q == '0)) begin
          state_d    = IDLE;
          final_beat = 1'b1;
        end
      end
      READ: begin
        if (issue) ram_addr = addr_q;
        if (pop && rd_last) begin
          state_d    = IDLE;
          final_beat = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      unissued_q      <= '0;
      last_addr_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= final_beat;
      if (cmd_hs) begin
        addr_q      <= cmd_addr;
        remaining_q <= cmd_len;
        unissued_q  <= {1'b0, cmd_len} + {{AW{1'b0}}, 1'b1};
      end else if (wr_hs) begin
        addr_q      <= next_addr(addr_q);
        remaining_q <= remaining_q - 1'b1;
      end else if (issue) begin
        addr_q     <= next_addr(addr_q);
        unissued_q <= unissued_q - 1'b1;
      end
      if (ram_we || issue) last_addr_q <= ram_addr;
      inflight_q      <= issue;
      inflight_last_q <= issue && (unissued_q == {{AW{1'b0}}, 1'b1});
    end
  end

  // Read-data buffer: RAM output lands here one edge after its address was issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last[0] <= 1'b0;
      buf_last[1] <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      if (push) begin
        buf_data[wr_ptr_q] <= ram_rdata;
        buf_last[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
